// File: rtl/decode_issue_queue.sv
// Decode-to-execute issue queue: a DEPTH-entry FIFO of decoded bundles with a
// per-GPR pending-write scoreboard that holds the head back on RAW hazards.
module decode_issue_queue #(
  parameter int PAYLOAD_W = 160,
  parameter int DEPTH     = 4,
  parameter int RADDR_W   = 5,
  parameter int PEND_W    = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       valid_pre_i,
  output logic                       ready_pre_o,
  input  logic [PAYLOAD_W-1:0]       payload_i,
  input  logic                       rena1_i,
  input  logic [RADDR_W-1:0]         raddr1_i,
  input  logic                       rena2_i,
  input  logic [RADDR_W-1:0]         raddr2_i,
  input  logic                       dec_wena_i,
  input  logic [RADDR_W-1:0]         dec_waddr_i,
  output logic                       valid_post_o,
  input  logic                       ready_post_i,
  output logic [PAYLOAD_W-1:0]       payload_o,
  output logic [RADDR_W-1:0]         waddr_o,
  input  logic                       flush_i,
  input  logic                       commit_wena_i,
  input  logic [RADDR_W-1:0]         commit_waddr_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       stall_o,
  output logic                       err_o
);

  localparam int                AW       = $clog2(DEPTH);
  localparam int                NREG     = 2 ** RADDR_W;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [AW:0]       FULL     = (AW + 1)'(DEPTH);

  logic [PAYLOAD_W-1:0] r_payload [DEPTH];
  logic                 r_rena1   [DEPTH];
  logic [RADDR_W-1:0]   r_raddr1  [DEPTH];
  logic                 r_rena2   [DEPTH];
  logic [RADDR_W-1:0]   r_raddr2  [DEPTH];
  logic                 r_wena    [DEPTH];
  logic [RADDR_W-1:0]   r_waddr   [DEPTH];

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_err;

  logic [NREG-1:0][PEND_W-1:0] w_pend;

  logic                 w_h_rena1;
  logic [RADDR_W-1:0]   w_h_raddr1;
  logic                 w_h_rena2;
  logic [RADDR_W-1:0]   w_h_raddr2;
  logic                 w_h_wena;
  logic [RADDR_W-1:0]   w_h_waddr;
  logic                 w_nonempty;
  logic                 w_hazard;
  logic                 w_push;
  logic                 w_issue;
  logic                 w_commit;

  assign w_h_rena1  = r_rena1[r_rptr];
  assign w_h_raddr1 = r_raddr1[r_rptr];
  assign w_h_rena2  = r_rena2[r_rptr];
  assign w_h_raddr2 = r_raddr2[r_rptr];
  assign w_h_wena   = r_wena[r_rptr];
  assign w_h_waddr  = r_waddr[r_rptr];

  assign w_nonempty = (r_count != '0);

  // The last term keeps a fourth in-flight write from overflowing its counter.
  assign w_hazard = (w_h_rena1 && (w_h_raddr1 != '0) && (w_pend[w_h_raddr1] != '0)) ||
                    (w_h_rena2 && (w_h_raddr2 != '0) && (w_pend[w_h_raddr2] != '0)) ||
                    (w_h_wena  && (w_h_waddr  != '0) && (w_pend[w_h_waddr] == PEND_MAX));

  assign ready_pre_o  = (r_count != FULL);
  assign valid_post_o = w_nonempty && !w_hazard && !flush_i;
  assign stall_o      = w_nonempty && w_hazard;
  assign payload_o    = r_payload[r_rptr];
  assign waddr_o      = w_h_wena ? w_h_waddr : '0;
  assign count_o      = r_count;
  assign err_o        = r_err;

  assign w_push   = valid_pre_i && ready_pre_o && !flush_i;
  assign w_issue  = valid_post_o && ready_post_i;
  assign w_commit = commit_wena_i && (commit_waddr_i != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_payload[i] <= '0;
        r_rena1[i]   <= 1'b0;
        r_raddr1[i]  <= '0;
        r_rena2[i]   <= 1'b0;
        r_raddr2[i]  <= '0;
        r_wena[i]    <= 1'b0;
        r_waddr[i]   <= '0;
      end
    end else if (w_push) begin
      r_payload[r_wptr] <= payload_i;
      r_rena1[r_wptr]   <= rena1_i;
      r_raddr1[r_wptr]  <= raddr1_i;
      r_rena2[r_wptr]   <= rena2_i;
      r_raddr2[r_wptr]  <= raddr2_i;
      r_wena[r_wptr]    <= dec_wena_i;
      r_waddr[r_wptr]   <= dec_waddr_i;
    end
  end

  // Pointers are exactly AW bits wide so they wrap modulo DEPTH on their own.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_issue)
        r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      r_err <= 1'b0;
    else if (w_commit && (w_pend[commit_waddr_i] == '0))
      r_err <= 1'b1;
  end

  // Scoreboard survives flush: bundles already issued will still commit.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
      if (gi == 0) begin : g_x0
        assign w_pend[gi] = '0;
      end else begin : g_reg
        logic              w_inc;
        logic              w_dec;
        logic [PEND_W-1:0] r_cnt;

        assign w_inc = w_issue && w_h_wena && (w_h_waddr == RADDR_W'(gi));
        assign w_dec = w_commit && (commit_waddr_i == RADDR_W'(gi));

        always_ff @(posedge clock or negedge reset) begin
          if (!reset)
            r_cnt <= '0;
          else if (w_inc && !w_dec)
            r_cnt <= r_cnt + 1'b1;
          else if (w_dec && !w_inc && (r_cnt != '0))
            r_cnt <= r_cnt - 1'b1;
        end

        assign w_pend[gi] = r_cnt;
      end
    end
  endgenerate

endmodule

// File: tb/tb_decode_issue_queue.sv
// Bench for decode_issue_queue: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a queue/array reference model.
module tb_decode_issue_queue;

  localparam int PW    = 160;
  localparam int DEPTH = 4;
  localparam int RW    = 5;
  localparam int PMAX  = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          valid_pre_i = 1'b0;
  logic          ready_pre_o;
  logic [PW-1:0] payload_i = '0;
  logic          rena1_i = 1'b0;
  logic [RW-1:0] raddr1_i = '0;
  logic          rena2_i = 1'b0;
  logic [RW-1:0] raddr2_i = '0;
  logic          dec_wena_i = 1'b0;
  logic [RW-1:0] dec_waddr_i = '0;
  logic          valid_post_o;
  logic          ready_post_i = 1'b0;
  logic [PW-1:0] payload_o;
  logic [RW-1:0] waddr_o;
  logic          flush_i = 1'b0;
  logic          commit_wena_i = 1'b0;
  logic [RW-1:0] commit_waddr_i = '0;
  logic [2:0]    count_o;
  logic          stall_o;
  logic          err_o;

  decode_issue_queue #(.PAYLOAD_W(PW), .DEPTH(DEPTH), .RADDR_W(RW), .PEND_W(2)) dut (
    .clock(clock), .reset(reset),
    .valid_pre_i(valid_pre_i), .ready_pre_o(ready_pre_o), .payload_i(payload_i),
    .rena1_i(rena1_i), .raddr1_i(raddr1_i), .rena2_i(rena2_i), .raddr2_i(raddr2_i),
    .dec_wena_i(dec_wena_i), .dec_waddr_i(dec_waddr_i),
    .valid_post_o(valid_post_o), .ready_post_i(ready_post_i),
    .payload_o(payload_o), .waddr_o(waddr_o), .flush_i(flush_i),
    .commit_wena_i(commit_wena_i), .commit_waddr_i(commit_waddr_i),
    .count_o(count_o), .stall_o(stall_o), .err_o(err_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [PW-1:0] payload;
    logic          rena1;
    logic [RW-1:0] raddr1;
    logic          rena2;
    logic [RW-1:0] raddr2;
    logic          wena;
    logic [RW-1:0] waddr;
  } bundle_t;

  bundle_t m_q[$];
  int      m_pend[32];
  bit      m_err;

  int checks   = 0;
  int failures = 0;
  bit s_vpost, s_stall;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_hazard(input bundle_t b);
    return (b.rena1 && b.raddr1 != 0 && m_pend[b.raddr1] != 0) ||
           (b.rena2 && b.raddr2 != 0 && m_pend[b.raddr2] != 0) ||
           (b.wena  && b.waddr  != 0 && m_pend[b.waddr] == PMAX);
  endfunction

  task automatic idle();
    valid_pre_i = 0; payload_i = '0; rena1_i = 0; raddr1_i = '0; rena2_i = 0; raddr2_i = '0;
    dec_wena_i = 0; dec_waddr_i = '0; ready_post_i = 0; flush_i = 0;
    commit_wena_i = 0; commit_waddr_i = '0;
  endtask

  task automatic bun(input logic r1e, input int r1, input logic r2e, input int r2,
                     input logic we, input int wa);
    valid_pre_i = 1;
    payload_i   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    rena1_i = r1e; raddr1_i = RW'(r1); rena2_i = r2e; raddr2_i = RW'(r2);
    dec_wena_i = we; dec_waddr_i = RW'(wa);
  endtask

  // Called at posedge+1 with inputs set; compares at negedge, advances the model, returns at next posedge+1.
  task automatic step();
    bit      haz, exp_v, exp_s, issue, push;
    int      inc_r, dec_r;
    bundle_t cur;
    #4;
    haz   = (m_q.size() != 0) && model_hazard(m_q[0]);
    exp_v = (m_q.size() != 0) && !haz && !flush_i;
    exp_s = (m_q.size() != 0) && haz;
    check("count", PW'(count_o), PW'(m_q.size()));
    check("ready_pre", PW'(ready_pre_o), PW'(m_q.size() != DEPTH));
    check("valid_post", PW'(valid_post_o), PW'(exp_v));
    check("stall", PW'(stall_o), PW'(exp_s));
    check("err", PW'(err_o), PW'(m_err));
    if (m_q.size() != 0) begin
      check("payload", payload_o, m_q[0].payload);
      check("waddr", PW'(waddr_o), PW'(m_q[0].wena ? m_q[0].waddr : 5'd0));
    end
    s_vpost = valid_post_o;
    s_stall = stall_o;

    issue = exp_v && ready_post_i;
    push  = !flush_i && valid_pre_i && (m_q.size() != DEPTH);
    inc_r = (issue && m_q[0].wena && m_q[0].waddr != 0) ? int'(m_q[0].waddr) : 0;
    dec_r = (commit_wena_i && commit_waddr_i != 0) ? int'(commit_waddr_i) : 0;
    if (dec_r != 0 && m_pend[dec_r] == 0) m_err = 1;
    if (inc_r != dec_r) begin
      if (inc_r != 0) m_pend[inc_r]++;
      if (dec_r != 0 && m_pend[dec_r] > 0) m_pend[dec_r]--;
    end
    cur = '{payload_i, rena1_i, raddr1_i, rena2_i, raddr2_i, dec_wena_i, dec_waddr_i};
    if (flush_i) m_q.delete();
    else begin
      if (issue) void'(m_q.pop_front());
      if (push) m_q.push_back(cur);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 0;
    @(posedge clock);
    @(posedge clock);
    #1;
    check("rst_count", PW'(count_o), 0);
    check("rst_ready_pre", PW'(ready_pre_o), 1);
    check("rst_valid_post", PW'(valid_post_o), 0);
    check("rst_stall", PW'(stall_o), 0);
    check("rst_err", PW'(err_o), 0);
    check("rst_payload", payload_o, 0);
    check("rst_waddr", PW'(waddr_o), 0);
    m_q.delete();
    foreach (m_pend[i]) m_pend[i] = 0;
    m_err = 0;
    reset = 1;
  endtask

  initial begin
    int nlist;
    int list[32];
    do_reset();

    // Single bundle writing x5 issues on its second cycle.
    idle(); bun(0, 0, 0, 0, 1, 5); ready_post_i = 1; step();
    check("t1_c1_vpost", PW'(s_vpost), 0);
    idle(); ready_post_i = 1; step();
    check("t1_c2_vpost", PW'(s_vpost), 1);
    check("t1_count", PW'(count_o), 0);
    check("t1_model_pend5", PW'(m_pend[5]), 1);

    // Reader of x5 stalls until the cycle after the commit.
    idle(); bun(1, 5, 0, 0, 0, 0); step();
    for (int i = 0; i < 3; i++) begin
      idle(); ready_post_i = 1; step();
      check("t2_stall", PW'(s_stall), 1);
      check("t2_vpost", PW'(s_vpost), 0);
    end
    idle(); ready_post_i = 1; commit_wena_i = 1; commit_waddr_i = 5; step();
    check("t2_commit_cycle_stall", PW'(s_stall), 1);
    idle(); ready_post_i = 1; step();
    check("t2_after_vpost", PW'(s_vpost), 1);
    check("t2_count", PW'(count_o), 0);

    // Fill, reject when full, single pop frees one slot.
    do_reset();
    for (int i = 0; i < 4; i++) begin idle(); bun(0, 0, 0, 0, 0, 0); step(); end
    check("t3_full_count", PW'(count_o), 4);
    check("t3_full_ready", PW'(ready_pre_o), 0);
    idle(); bun(0, 0, 0, 0, 0, 0); step();
    check("t3_5th_dropped", PW'(count_o), 4);
    idle(); ready_post_i = 1; step();
    check("t3_pop_count", PW'(count_o), 3);
    check("t3_pop_ready", PW'(ready_pre_o), 1);

    // Four writers of x7: the fourth hits pending saturation.
    do_reset();
    for (int i = 0; i < 4; i++) begin idle(); bun(0, 0, 0, 0, 1, 7); ready_post_i = 1; step(); end
    idle(); ready_post_i = 1; step();
    check("t4_sat_stall", PW'(s_stall), 1);
    check("t4_sat_vpost", PW'(s_vpost), 0);
    check("t4_model_pend7", PW'(m_pend[7]), 3);
    idle(); ready_post_i = 1; commit_wena_i = 1; commit_waddr_i = 7; step();
    check("t4_commit_cycle_stall", PW'(s_stall), 1);
    idle(); ready_post_i = 1; step();
    check("t4_unblocked", PW'(s_vpost), 1);

    // Commit to x0 is ignored; commit to idle x9 sets sticky error.
    do_reset();
    idle(); commit_wena_i = 1; commit_waddr_i = 0; step();
    check("t5_x0_err", PW'(err_o), 0);
    idle(); commit_wena_i = 1; commit_waddr_i = 9; step();
    check("t5_x9_err", PW'(err_o), 1);
    idle(); step();
    check("t5_sticky", PW'(err_o), 1);

    // Flush empties the queue but keeps the scoreboard.
    do_reset();
    idle(); bun(0, 0, 0, 0, 1, 5); ready_post_i = 1; step();
    idle(); ready_post_i = 1; step();
    for (int i = 0; i < 3; i++) begin idle(); bun(0, 0, 0, 0, 0, 0); step(); end
    check("t6_count3", PW'(count_o), 3);
    idle(); bun(0, 0, 0, 0, 0, 0); flush_i = 1; ready_post_i = 1; step();
    check("t6_flush_vpost", PW'(s_vpost), 0);
    check("t6_flush_count", PW'(count_o), 0);
    idle(); bun(1, 5, 0, 0, 0, 0); step();
    idle(); ready_post_i = 1; step();
    check("t6_pend_kept_stall", PW'(s_stall), 1);
    check("t6_model_pend5", PW'(m_pend[5]), 1);

    // Randomized traffic with periodic resets.
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int c = 0; c < 1000; c++) begin
        idle();
        if ($urandom_range(0, 99) < 60)
          bun($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
              $urandom_range(0, 7), $urandom_range(0, 9) < 7, $urandom_range(0, 7));
        ready_post_i = ($urandom_range(0, 99) < 70);
        flush_i      = ($urandom_range(0, 99) < 3);
        if ($urandom_range(0, 99) < 40) begin
          nlist = 0;
          for (int r = 1; r < 32; r++) if (m_pend[r] > 0) begin list[nlist] = r; nlist++; end
          commit_wena_i = 1;
          if (nlist > 0 && $urandom_range(0, 99) < 95)
            commit_waddr_i = RW'(list[$urandom_range(0, nlist - 1)]);
          else
            commit_waddr_i = RW'($urandom_range(0, 31));
        end
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
